// File: rtl/mcp_pkg.sv
// mcp_pkg: shared types and constants for the MCP23S17 sequencer.
// Holds the FSM state enum, opcode base, register map subset and IOCON bits.
package mcp_pkg;

  typedef enum logic [2:0] {
    Idle,
    CsSetup,
    SendOp,
    SendReg,
    SendData,
    CsHold,
    Respond,
    Init
  } McpState;

  localparam logic [7:0] OPCODE_BASE = 8'h40;

  localparam logic [7:0] IOCON  = 8'h0A;
  localparam logic [7:0] IODIRA = 8'h00;
  localparam logic [7:0] GPIOA  = 8'h12;
  localparam logic [7:0] OLATA  = 8'h14;

  localparam logic [7:0] HAEN = 8'h08;

  // Opcode: 0100 A2 A1 A0 R/W
  function automatic logic [7:0] mcp_opcode(
    input logic [2:0] addr,
    input logic       rw
  );
    return OPCODE_BASE | {4'b0000, addr, rw};
  endfunction

endpackage

// File: rtl/mcp_delay_counter.sv
// mcp_delay_counter: 4-bit load / count-down timer with a zero flag.
// Ports: sysClk, reset (sync, high), load + load_val, en (count), zero.
module mcp_delay_counter (
  input  logic       sysClk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge sysClk) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/mcp23s17_sequencer.sv
// mcp23s17_sequencer: runs one MCP23S17 register read/write as a
// three-byte SPI frame (opcode, reg, data) with /CS setup/hold spacing.
// Ports: sysClk, reset (sync, high); cmd_valid/ready, cmd_rw, cmd_reg,
// cmd_wdata; rsp_valid, rsp_rdata; busy; cs_n; spi_start, spi_tx_byte,
// spi_done, spi_rx_byte.
// Build option MCP_INIT_EN: after reset, write IOCON = HAEN once
// (opcode 8'h40, no response pulse) before accepting commands.
module mcp23s17_sequencer
  import mcp_pkg::*;
#(
  parameter logic [2:0] DEV_ADDR = 3'b000,
  parameter logic [3:0] CS_SETUP = 4'd4,
  parameter logic [3:0] CS_HOLD  = 4'd4
) (
  input  logic       sysClk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       cs_n,
  output logic       spi_start,
  output logic [7:0] spi_tx_byte,
  input  logic       spi_done,
  input  logic [7:0] spi_rx_byte
);

  localparam logic [3:0] SETUP_LD = CS_SETUP - 4'd1;
  localparam logic [3:0] HOLD_LD  = CS_HOLD - 4'd1;

  McpState    state;
  logic       rw_q;
  logic [7:0] reg_q;
  logic [7:0] wdata_q;
  logic [7:0] rd_q;
  logic       init_q;

  logic       accept;
  logic       hold_ld;
  logic       dly_load;
  logic [3:0] dly_val;
  logic       dly_en;
  logic       dly_zero;

  assign accept  = (state == Idle) && cmd_valid && cmd_ready;
  assign hold_ld = (state == SendData) && spi_done;

  // One timer serves both /CS gaps; load on entry, count in the gap.
  always_comb begin
    dly_load = 1'b0;
    dly_val  = SETUP_LD;
    unique case (1'b1)
      accept: begin
        dly_load = 1'b1;
      end
      (state == Init): begin
        dly_load = 1'b1;
      end
      hold_ld: begin
        dly_load = 1'b1;
        dly_val  = HOLD_LD;
      end
      default: ;
    endcase
  end

  assign dly_en = (state == CsSetup) || (state == CsHold);

  mcp_delay_counter u_dly (
    .sysClk   (sysClk),
    .reset    (reset),
    .load     (dly_load),
    .load_val (dly_val),
    .en       (dly_en),
    .zero     (dly_zero)
  );

  always_ff @(posedge sysClk) begin
    if (reset) begin
`ifdef MCP_INIT_EN
      state       <= Init;
`else
      state       <= Idle;
`endif
      cs_n        <= 1'b1;
      spi_start   <= 1'b0;
      spi_tx_byte <= 8'h00;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 8'h00;
      busy        <= 1'b0;
      rw_q        <= 1'b0;
      reg_q       <= 8'h00;
      wdata_q     <= 8'h00;
      rd_q        <= 8'h00;
      init_q      <= 1'b0;
    end else begin
      spi_start <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      unique case (state)
        Init: begin
          rw_q    <= 1'b0;
          reg_q   <= IOCON;
          wdata_q <= HAEN;
          init_q  <= 1'b1;
          busy    <= 1'b1;
          cs_n    <= 1'b0;
          state   <= CsSetup;
        end
        Idle: begin
          if (accept) begin
            rw_q      <= cmd_rw;
            reg_q     <= cmd_reg;
            wdata_q   <= cmd_wdata;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            cs_n      <= 1'b0;
            state     <= CsSetup;
          end else begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        CsSetup: begin
          if (dly_zero) begin
            spi_start <= 1'b1;
            // HAEN is off until the init write lands, so use A=000.
            spi_tx_byte <= init_q ? OPCODE_BASE
                                  : mcp_opcode(DEV_ADDR, rw_q);
            state <= SendOp;
          end
        end
        SendOp: begin
          if (spi_done) begin
            spi_start   <= 1'b1;
            spi_tx_byte <= reg_q;
            state       <= SendReg;
          end
        end
        SendReg: begin
          if (spi_done) begin
            spi_start   <= 1'b1;
            spi_tx_byte <= rw_q ? 8'h00 : wdata_q;
            state       <= SendData;
          end
        end
        SendData: begin
          if (spi_done) begin
            rd_q  <= rw_q ? spi_rx_byte : 8'h00;
            state <= CsHold;
          end
        end
        CsHold: begin
          if (dly_zero) begin
            cs_n  <= 1'b1;
            state <= Respond;
          end
        end
        Respond: begin
          if (!init_q) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= rd_q;
          end
          init_q    <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= Idle;
        end
        default: state <= Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_mcp23s17_sequencer.sv
// tb_mcp23s17_sequencer: directed bench for mcp23s17_sequencer.
// Plays the SPI master (2-cycle byte time) and checks frames and timing.
module tb_mcp23s17_sequencer;

  localparam int BT = 2;

  logic       sysClk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       cs_n;
  logic       spi_start;
  logic [7:0] spi_tx_byte;
  logic       spi_done;
  logic [7:0] spi_rx_byte;

  logic       cmd_ready5;
  logic       rsp_valid5;
  logic [7:0] rsp_rdata5;
  logic       busy5;
  logic       cs_n5;
  logic       spi_start5;
  logic [7:0] spi_tx_byte5;

  int vectors;
  int miscompares;

  mcp23s17_sequencer #(
    .DEV_ADDR (3'b000),
    .CS_SETUP (4'd2),
    .CS_HOLD  (4'd3)
  ) u_dut (
    .sysClk      (sysClk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rw      (cmd_rw),
    .cmd_reg     (cmd_reg),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .busy        (busy),
    .cs_n        (cs_n),
    .spi_start   (spi_start),
    .spi_tx_byte (spi_tx_byte),
    .spi_done    (spi_done),
    .spi_rx_byte (spi_rx_byte)
  );

  // Same timing, different hardware address: shares the handshake.
  mcp23s17_sequencer #(
    .DEV_ADDR (3'b101),
    .CS_SETUP (4'd2),
    .CS_HOLD  (4'd3)
  ) u_dut5 (
    .sysClk      (sysClk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready5),
    .cmd_rw      (cmd_rw),
    .cmd_reg     (cmd_reg),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid5),
    .rsp_rdata   (rsp_rdata5),
    .busy        (busy5),
    .cs_n        (cs_n5),
    .spi_start   (spi_start5),
    .spi_tx_byte (spi_tx_byte5),
    .spi_done    (spi_done),
    .spi_rx_byte (spi_rx_byte)
  );

  initial begin
    sysClk = 1'b0;
    forever #5 sysClk = ~sysClk;
  end

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for spi_start, record the byte, answer with rx after BT cycles.
  task automatic serve(
    input  string      tag,
    input  logic [7:0] rx,
    output logic [7:0] tx,
    output logic [7:0] tx5,
    output int         n
  );
    n = 0;
    while (spi_start !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    tx  = spi_tx_byte;
    tx5 = spi_tx_byte5;
    check({tag, ".cs_low"}, {31'd0, cs_n}, 32'd0);
    check({tag, ".start5"}, {31'd0, spi_start5}, 32'd1);
    check({tag, ".cs5_low"}, {31'd0, cs_n5}, 32'd0);
    tick();
    check({tag, ".pulse"}, {31'd0, spi_start}, 32'd0);
    repeat (BT - 1) tick();
    check({tag, ".tx_hold"}, {24'd0, spi_tx_byte}, {24'd0, tx});
    spi_done    = 1'b1;
    spi_rx_byte = rx;
    tick();
    spi_done    = 1'b0;
    spi_rx_byte = 8'hEE;
  endtask

  // Starts in the cycle after accept; ends in the rsp_valid cycle.
  task automatic frame(
    input string      tag,
    input logic [7:0] e0,
    input logic [7:0] e1,
    input logic [7:0] e2,
    input logic [7:0] rx,
    input logic [7:0] erd,
    input logic [7:0] e5,
    input int         esetup,
    input bit         quiet
  );
    logic [7:0] t;
    logic [7:0] t5;
    int         n;
    check({tag, ".cs_fall"}, {31'd0, cs_n}, 32'd0);
    serve({tag, ".b0"}, 8'h00, t, t5, n);
    check({tag, ".setup"}, n, esetup);
    check({tag, ".op"}, {24'd0, t}, {24'd0, e0});
    check({tag, ".op5"}, {24'd0, t5}, {24'd0, e5});
    serve({tag, ".b1"}, 8'h00, t, t5, n);
    check({tag, ".chain1"}, n, 32'd0);
    check({tag, ".reg"}, {24'd0, t}, {24'd0, e1});
    serve({tag, ".b2"}, rx, t, t5, n);
    check({tag, ".chain2"}, n, 32'd0);
    check({tag, ".data"}, {24'd0, t}, {24'd0, e2});
    n = 0;
    while (cs_n === 1'b0 && n < 40) begin
      n++;
      tick();
    end
    check({tag, ".hold"}, n, 32'd3);
    check({tag, ".rsp_early"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, ".busy_resp"}, {31'd0, busy}, 32'd1);
    tick();
    check({tag, ".rsp_valid"}, {31'd0, rsp_valid}, {31'd0, !quiet});
    check({tag, ".rdata"}, {24'd0, rsp_rdata}, quiet ? 32'd0 : {24'd0, erd});
    check({tag, ".ready"}, {31'd0, cmd_ready}, 32'd1);
    check({tag, ".busy_end"}, {31'd0, busy}, 32'd0);
    check({tag, ".cs_high"}, {31'd0, cs_n}, 32'd1);
  endtask

  // Hold cmd_valid with the given command until it is accepted.
  task automatic issue(
    input string      tag,
    input logic       rw,
    input logic [7:0] rg,
    input logic [7:0] wd
  );
    int n;
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_reg   = rg;
    cmd_wdata = wd;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, ".accept"}, {31'd0, cmd_ready}, 32'd1);
    tick();
  endtask

  task automatic post_reset(input string tag);
    reset = 1'b0;
    tick();
`ifdef MCP_INIT_EN
    check({tag, ".init_ready"}, {31'd0, cmd_ready}, 32'd0);
    check({tag, ".init_busy"}, {31'd0, busy}, 32'd1);
    frame({tag, ".init"}, 8'h40, 8'h0A, 8'h08, 8'h00, 8'h00, 8'h40, 2, 1'b1);
`else
    check({tag, ".ready"}, {31'd0, cmd_ready}, 32'd1);
    check({tag, ".busy"}, {31'd0, busy}, 32'd0);
    check({tag, ".cs_n"}, {31'd0, cs_n}, 32'd1);
`endif
  endtask

  initial begin
    logic [7:0] t;
    logic [7:0] t5;
    int         n;

    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_rw      = 1'b0;
    cmd_reg     = 8'h00;
    cmd_wdata   = 8'h00;
    spi_done    = 1'b0;
    spi_rx_byte = 8'hEE;

    tick();
    tick();
    check("rst.cs_n", {31'd0, cs_n}, 32'd1);
    check("rst.start", {31'd0, spi_start}, 32'd0);
    check("rst.tx", {24'd0, spi_tx_byte}, 32'd0);
    check("rst.ready", {31'd0, cmd_ready}, 32'd0);
    check("rst.rsp", {31'd0, rsp_valid}, 32'd0);
    check("rst.rdata", {24'd0, rsp_rdata}, 32'd0);
    check("rst.busy", {31'd0, busy}, 32'd0);
    post_reset("rel");

    // Write GPIOA = 55; rx on the data byte must be discarded.
    issue("wr", 1'b0, 8'h12, 8'h55);
    cmd_valid = 1'b0;
    frame("wr", 8'h40, 8'h12, 8'h55, 8'hA7, 8'h00, 8'h4A, 2, 1'b0);

    // Read GPIOA.
    tick();
    issue("rd", 1'b1, 8'h12, 8'h00);
    cmd_valid = 1'b0;
    frame("rd", 8'h41, 8'h12, 8'h00, 8'hC9, 8'hC9, 8'h4B, 2, 1'b0);

    // Back-to-back: OLATA write, then IODIRA read, valid held high.
    tick();
    issue("b2bA", 1'b0, 8'h14, 8'h3C);
    cmd_rw    = 1'b1;
    cmd_reg   = 8'h00;
    cmd_wdata = 8'hFF;
    frame("b2bA", 8'h40, 8'h14, 8'h3C, 8'h66, 8'h00, 8'h4A, 2, 1'b0);
    tick();
    cmd_valid = 1'b0;
    cmd_rw    = 1'b0;
    cmd_reg   = 8'hFF;
    cmd_wdata = 8'h11;
    frame("b2bB", 8'h41, 8'h00, 8'h00, 8'h5A, 8'h5A, 8'h4B, 2, 1'b0);

    // Stray spi_done in Idle and in CsSetup.
    tick();
    spi_done = 1'b1;
    tick();
    spi_done = 1'b0;
    check("stray_idle.cs_n", {31'd0, cs_n}, 32'd1);
    check("stray_idle.busy", {31'd0, busy}, 32'd0);
    check("stray_idle.start", {31'd0, spi_start}, 32'd0);
    check("stray_idle.ready", {31'd0, cmd_ready}, 32'd1);
    issue("stray", 1'b1, 8'h0A, 8'h00);
    cmd_valid = 1'b0;
    spi_done  = 1'b1;
    tick();
    spi_done  = 1'b0;
    check("stray_setup.start", {31'd0, spi_start}, 32'd0);
    check("stray_setup.cs_n", {31'd0, cs_n}, 32'd0);
    frame("stray", 8'h41, 8'h0A, 8'h00, 8'h3E, 8'h3E, 8'h4B, 1, 1'b0);

    // Reset while the register byte is in flight.
    tick();
    issue("mid", 1'b0, 8'h12, 8'hAA);
    cmd_valid = 1'b0;
    serve("mid.b0", 8'h00, t, t5, n);
    check("mid.sendreg", {31'd0, spi_start}, 32'd1);
    reset = 1'b1;
    tick();
    check("mid.cs_n", {31'd0, cs_n}, 32'd1);
    check("mid.busy", {31'd0, busy}, 32'd0);
    check("mid.start", {31'd0, spi_start}, 32'd0);
    check("mid.rsp", {31'd0, rsp_valid}, 32'd0);
    post_reset("mid_rel");
    issue("rd2", 1'b1, 8'h12, 8'h00);
    cmd_valid = 1'b0;
    frame("rd2", 8'h41, 8'h12, 8'h00, 8'h81, 8'h81, 8'h4B, 2, 1'b0);

    tick();
    check("end.rsp_low", {31'd0, rsp_valid}, 32'd0);
    check("end.rdata_low", {24'd0, rsp_rdata}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1, "watchdog");
  end

endmodule
